// File: rtl/demux_dist_if.sv
// rtl/demux_dist_if.sv - upstream beat, per-channel output and drop counter bundle for demux_dist
interface demux_dist_if #(
  parameter int DW  = 2,
  parameter int NCH = 31,
  parameter int CW  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_sel;
  logic [DW-1:0]     in_data;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready;
  logic [NCH*DW-1:0] out_data;
  logic [CW-1:0]     drop_count;

  // Upstream source and downstream sinks together.
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, drop_count
  );

  // The demultiplexer itself.
  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, drop_count
  );
endinterface

// File: rtl/demux_dist.sv
// rtl/demux_dist.sv - registered 1-to-31 demultiplexer with one-entry buffer per channel and drop counter
module demux_dist #(
  parameter int DW  = 2,
  parameter int NCH = 31,
  parameter int CW  = 8
) (
  input  logic        clk,
  input  logic        rst,
  demux_dist_if.slave bus
);

  // Select code 31 is the mux's default-output code; here it means "no destination".
  localparam logic [4:0] DROP_SEL = 5'd31;

  logic [NCH-1:0]    full_q, full_d;
  logic [NCH*DW-1:0] data_q, data_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic              rdy;
  logic              accept;

  // Ready looks only at the addressed channel; a drain in the same cycle frees the slot.
  always_comb begin
    rdy = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (bus.in_sel == 5'(i)) begin
        rdy = !full_q[i] || bus.out_ready[i];
      end
    end
  end

  assign accept = bus.in_valid && rdy;

  // Per-channel next state: pop clears, an accept overwrites and wins over a pop.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    drop_d = drop_q;
    for (int i = 0; i < NCH; i++) begin
      if (full_q[i] && bus.out_ready[i]) begin
        full_d[i] = 1'b0;
      end
      if (accept && (bus.in_sel == 5'(i))) begin
        full_d[i]           = 1'b1;
        data_d[i*DW +: DW]  = bus.in_data;
      end
    end
    if (accept && (bus.in_sel == DROP_SEL) && (drop_q != {CW{1'b1}})) begin
      drop_d = drop_q + CW'(1);
    end
  end

  // State registers; reset overrides any coincident accept or pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      data_q <= '0;
      drop_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      drop_q <= drop_d;
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.out_valid  = full_q;
  assign bus.out_data   = data_q;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_demux_dist.sv
// tb/tb_demux_dist.sv - randomized self-checking bench for demux_dist against a channel-array model
module tb_demux_dist;
  localparam int DW  = 2;
  localparam int NCH = 31;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  demux_dist_if #(.DW(DW), .NCH(NCH), .CW(CW)) bus ();
  demux_dist #(.DW(DW), .NCH(NCH), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Model: each channel is a one-slot buffer; drops are a saturating tally.
  bit       m_full [NCH];
  bit [1:0] m_data [NCH];
  int       m_drop;
  bit       seen_ready;
  bit       exp_ready;

  function automatic bit model_ready(input logic [4:0] s, input logic [NCH-1:0] ordy);
    if (s == 5'd31) return 1'b1;
    return !m_full[s] || ordy[s];
  endfunction

  function automatic logic [NCH-1:0] exp_valid();
    logic [NCH-1:0] v = '0;
    for (int i = 0; i < NCH; i++) v[i] = m_full[i];
    return v;
  endfunction

  function automatic logic [NCH*DW-1:0] exp_data();
    logic [NCH*DW-1:0] v = '0;
    for (int i = 0; i < NCH; i++) v[i*DW +: DW] = m_data[i];
    return v;
  endfunction

  // Drives one cycle from a negedge, samples in_ready before the edge, advances the model,
  // and returns at the following negedge with registered outputs settled.
  task automatic step(input logic v, input logic [4:0] s, input logic [1:0] d,
                      input logic [NCH-1:0] ordy, input logic r);
    rst           = r;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    seen_ready = bus.in_ready;
    exp_ready  = model_ready(s, ordy);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NCH; i++) begin m_full[i] = 0; m_data[i] = 0; end
      m_drop = 0;
    end else begin
      for (int i = 0; i < NCH; i++) if (m_full[i] && ordy[i]) m_full[i] = 0;
      if (v && exp_ready) begin
        if (s == 5'd31) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        else begin m_full[s] = 1; m_data[s] = d; end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1, 5'd3, 2'd2, '0, 1);
    step(1, 5'd3, 2'd2, '0, 1);
    rst = 0; bus.in_valid = 0; #1;
    vectors++;
    if (bus.out_valid !== 31'h0) begin miscompares++; $display("FAIL reset_valid got %h want 0", bus.out_valid); end
    vectors++;
    if (bus.out_data !== '0) begin miscompares++; $display("FAIL reset_data got %h want 0", bus.out_data); end
    vectors++;
    if (bus.drop_count !== 8'd0) begin miscompares++; $display("FAIL reset_drop got %0d want 0", bus.drop_count); end
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", bus.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic_route();
    step(1, 5'd5, 2'b10, '0, 0);
    vectors++;
    if (bus.out_valid !== 31'h20) begin miscompares++; $display("FAIL route_valid got %h want 00000020", bus.out_valid); end
    vectors++;
    if (bus.out_data[10 +: 2] !== 2'b10) begin miscompares++; $display("FAIL route_data got %b want 10", bus.out_data[10 +: 2]); end
    step(1, 5'd5, 2'b01, '0, 0);
    vectors++;
    if (seen_ready !== 1'b0) begin miscompares++; $display("FAIL route_stall got %b want 0", seen_ready); end
    step(1, 5'd5, 2'b01, 31'h20, 0);
    vectors++;
    if (seen_ready !== 1'b1) begin miscompares++; $display("FAIL route_wr_rd_ready got %b want 1", seen_ready); end
    vectors++;
    if (bus.out_valid !== 31'h20 || bus.out_data[10 +: 2] !== 2'b01) begin
      miscompares++; $display("FAIL route_overwrite got v=%h d=%b want v=00000020 d=01", bus.out_valid, bus.out_data[10 +: 2]);
    end
  endtask

  task automatic test_sweep();
    logic [NCH*DW-1:0] want;
    step(0, 5'd0, 2'd0, '0, 1);
    for (int s = 0; s < NCH; s++) step(1, 5'(s), 2'(s), '0, 0);
    want = '0;
    for (int i = 0; i < NCH; i++) want[i*DW +: DW] = 2'(i % 4);
    vectors++;
    if (bus.out_valid !== 31'h7FFF_FFFF) begin miscompares++; $display("FAIL sweep_valid got %h want 7fffffff", bus.out_valid); end
    vectors++;
    if (bus.out_data !== want) begin miscompares++; $display("FAIL sweep_data got %h want %h", bus.out_data, want); end
    for (int k = 0; k < 4; k++) begin
      step(1, 5'($urandom_range(0, 30)), 2'($urandom), '0, 0);
      vectors++;
      if (seen_ready !== 1'b0) begin miscompares++; $display("FAIL sweep_stall got %b want 0", seen_ready); end
    end
    step(0, 5'd0, 2'd0, 31'h1 << 17, 0);
    vectors++;
    if (bus.out_valid !== (31'h7FFF_FFFF & ~(31'h1 << 17))) begin
      miscompares++; $display("FAIL sweep_drain17 got %h want 7ffdffff", bus.out_valid);
    end
  endtask

  task automatic test_drop();
    step(0, 5'd0, 2'd0, '0, 1);
    step(1, 5'd2, 2'd3, '0, 0);
    for (int k = 0; k < 300; k++) begin
      step(1, 5'd31, 2'($urandom), '0, 0);
      vectors++;
      if (seen_ready !== 1'b1 || bus.drop_count !== 8'(m_drop)) begin
        miscompares++; $display("FAIL drop_beat%0d got rdy=%b cnt=%0d want rdy=1 cnt=%0d", k, seen_ready, bus.drop_count, m_drop);
      end
    end
    vectors++;
    if (bus.drop_count !== 8'd255) begin miscompares++; $display("FAIL drop_saturate got %0d want 255", bus.drop_count); end
    vectors++;
    if (bus.out_valid !== 31'h4 || bus.out_data[4 +: 2] !== 2'd3) begin
      miscompares++; $display("FAIL drop_channels got v=%h want 00000004", bus.out_valid);
    end
  endtask

  task automatic test_streaming();
    logic [4:0] s;
    logic [1:0] d;
    step(0, 5'd0, 2'd0, '0, 1);
    for (int k = 0; k < 100; k++) begin
      s = 5'($urandom_range(0, 30));
      d = 2'($urandom);
      step(1, s, d, {NCH{1'b1}}, 0);
      vectors++;
      if (seen_ready !== 1'b1 || bus.out_valid !== (31'h1 << s) || bus.out_data[s*DW +: DW] !== d) begin
        miscompares++;
        $display("FAIL stream_beat%0d got rdy=%b v=%h d=%b want rdy=1 v=%h d=%b",
                 k, seen_ready, bus.out_valid, bus.out_data[s*DW +: DW], 31'h1 << s, d);
      end
    end
  endtask

  task automatic test_random_mix();
    logic [4:0] s;
    logic [NCH-1:0] ordy;
    step(0, 5'd0, 2'd0, '0, 1);
    for (int k = 0; k < 300; k++) begin
      s    = 5'($urandom_range(0, 31));
      ordy = NCH'($urandom) & NCH'($urandom);
      step(1'($urandom), s, 2'($urandom), ordy, 0);
      vectors++;
      if (seen_ready !== exp_ready || bus.out_valid !== exp_valid() ||
          bus.out_data !== exp_data() || bus.drop_count !== 8'(m_drop)) begin
        miscompares++;
        $display("FAIL mix_cycle%0d got rdy=%b v=%h d=%h c=%0d want rdy=%b v=%h d=%h c=%0d", k,
                 seen_ready, bus.out_valid, bus.out_data, bus.drop_count,
                 exp_ready, exp_valid(), exp_data(), m_drop);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(0, 5'd0, 2'd0, '0, 1);
    step(1, 5'd0, 2'd1, '0, 0);
    step(1, 5'd9, 2'd2, '0, 0);
    step(1, 5'd30, 2'd3, '0, 0);
    for (int k = 0; k < 4; k++) step(1, 5'd31, 2'd0, '0, 0);
    vectors++;
    if (bus.out_valid !== 31'h4000_0201 || bus.drop_count !== 8'd4) begin
      miscompares++; $display("FAIL mid_setup got v=%h c=%0d want v=40000201 c=4", bus.out_valid, bus.drop_count);
    end
    step(1, 5'd12, 2'd3, '0, 1);
    vectors++;
    if (bus.out_valid !== 31'h0 || bus.out_data !== '0 || bus.drop_count !== 8'd0) begin
      miscompares++; $display("FAIL mid_reset_accept got v=%h d=%h c=%0d want all 0", bus.out_valid, bus.out_data, bus.drop_count);
    end
    step(1, 5'd31, 2'd0, '0, 1);
    vectors++;
    if (bus.drop_count !== 8'd0) begin miscompares++; $display("FAIL mid_reset_drop got %0d want 0", bus.drop_count); end
  endtask

  initial begin
    bus.in_valid  = 0;
    bus.in_sel    = 0;
    bus.in_data   = 0;
    bus.out_ready = '0;
    m_drop        = 0;
    @(negedge clk);
    test_reset();
    test_basic_route();
    test_sweep();
    test_drop();
    test_streaming();
    test_random_mix();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/demux_dist.md
# demux_dist

Registered 1-to-31 demultiplexer: the distribution side of the team's 31-input, 2-bit, 5-bit-select mux. One upstream stream carries 2-bit data plus a 5-bit destination select; each accepted beat is latched into a one-entry buffer for the selected output channel and presented there with a valid/ready handshake. Select code 31, which the mux maps to its default output 0, is treated as "no destination": the beat is dropped and counted.

## Interface
- DW, default 2: data width per channel. Fixed at 2 for the mux pairing.
- NCH, default 31: number of output channels. Fixed at 31; selects 0..30 are valid, 31 is the drop code.
- CW, default 8: drop counter width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  upstream beat accepted this cycle when high together with in_valid.
- in_sel  input  5  destination channel; 31 means drop.
- in_data  input  DW  beat payload.
- out_valid  output  NCH  per-channel buffer-full flag; bit i is channel i.
- out_ready  input  NCH  per-channel downstream ready.
- out_data  output  NCH*DW  channel i occupies bits [DW*i+DW-1 : DW*i].
- drop_count  output  CW  saturating count of beats accepted with in_sel = 31.

## Operation
- Per-channel state: full[i] (drives out_valid[i]) and data register d[i] (drives out_data slice i).
- in_ready, combinational from in_sel, full and out_ready:
  - in_sel = 31: in_ready = 1. A drop never stalls.
  - in_sel = s < 31: in_ready = !full[s] | out_ready[s]. Write-while-read is allowed, so a full channel being drained this cycle still accepts.
- Accept = in_valid & in_ready.
- Channel i update each cycle, with acc_i = accept & (in_sel == i) and pop_i = full[i] & out_ready[i]:
  - acc_i = 1: d[i] <= in_data and full[i] <= 1, whether or not pop_i is set.
  - acc_i = 0 and pop_i = 1: full[i] <= 0, d[i] holds.
  - Otherwise hold.
- Drop: accept with in_sel = 31 increments drop_count. It saturates at 2^CW-1 (255) and does not wrap. No channel changes state.
- Other channels are unaffected by any accept; all 31 channels drain independently and concurrently.
- out_data slice i is meaningful only while out_valid[i] = 1. It retains its last value after a pop.
- No internal FSM beyond the per-channel full flags. Ordering is preserved per channel; there is no ordering guarantee across channels.

## Timing
- Reset (rst = 1 at a rising edge): out_valid = 0, all out_data = 0, drop_count = 0. in_ready then follows the combinational rule, which gives 1 for every in_sel. Reset overrides any accept or pop in the same cycle; a beat presented during reset is lost and is not counted.
- Latency: a beat accepted at edge N appears at out_valid[s] / out_data slice s immediately after edge N. One cycle, registered.
- Throughput: 1 beat per cycle into any single channel while its out_ready is held high. Back-to-back beats to different channels also sustain 1 per cycle.
- Stall: if channel s is full and out_ready[s] = 0, in_ready = 0 for in_sel = s. Upstream must hold in_valid, in_sel and in_data stable until accepted.
- Downstream rule: once out_valid[i] rises it stays high with stable data until a cycle with out_ready[i] = 1.
- The in_ready path depends combinationally on out_ready[in_sel]. There is no other combinational input-to-output path; out_valid, out_data and drop_count are all registered.

## Test plan
- Reset: drive rst = 1 for 2 cycles with in_valid = 1, in_sel = 3 -> out_valid = 0, out_data = 0, drop_count = 0 after release.
- Basic route: in_sel = 5, in_data = 2'b10, out_ready = 0 -> after the next edge out_valid = 31'h20 and slice 5 = 2'b10. A second beat to sel 5 sees in_ready = 0. Raise out_ready[5] -> that beat is accepted in the same cycle, slice 5 takes the new data and out_valid[5] stays 1.
- Sweep: sel 0..30 with in_data = sel[1:0], all out_ready = 0 -> out_valid = 31'h7FFF_FFFF and each slice i = i mod 4. Further beats stall. Release out_ready[17] only -> only out_valid[17] clears.
- Drop: 300 consecutive beats with in_sel = 31 -> in_ready stays 1, out_valid unchanged, drop_count = 255 (saturated).
- Streaming: all out_ready = 1, 100 random beats to random sel 0..30 -> in_ready always 1 and each beat observed exactly once, one cycle later, on its channel.
- Reset mid-traffic: channels 0, 9 and 30 full and drop_count = 4, then assert rst together with an accept -> all cleared, and no new state from the coincident beat.
